// File: rtl/inst_sequencer.sv
// Weight-stationary tile sequencer: drives the core's 53-bit instruction word
// through weight fetch, kernel load, activation fetch, execute and OFIFO drain.
module inst_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] cfg_w_base,
  input  logic [10:0] cfg_a_base,
  input  logic [10:0] cfg_o_base,
  input  logic [10:0] cfg_len,
  input  logic        ofifo_valid,
  output logic [52:0] inst,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);
  localparam logic [52:0] IDLE_WORD = 53'h0006_0001_800C_0000;
  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [11:0] ROW       = 12'(row);
  localparam logic [11:0] COL       = 12'(col);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_W_SETTLE, S_A_FETCH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [11:0]   cnt, cnt_d, plen;
  logic [10:0]   written, written_d;
  logic [TW-1:0] idle, idle_d;
  logic [10:0]   w_base, a_base, o_base, len;
  logic [52:0]   inst_d;
  logic          done_d, terr_d, last;

  // Length of the timed phase currently running; fetches carry one extra
  // cycle for the SRAM read latency.
  always_comb begin
    plen = {1'b0, len};
    case (state)
      S_W_FETCH:  plen = ROW + 12'd1;
      S_W_LOAD:   plen = ROW;
      S_W_SETTLE: plen = COL;
      S_A_FETCH:  plen = {1'b0, len} + 12'd1;
      default:    plen = {1'b0, len};
    endcase
  end
  assign last = (cnt == plen - 12'd1);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_d   = state;
    cnt_d     = '0;
    written_d = written;
    idle_d    = '0;
    inst_d    = IDLE_WORD;
    done_d    = 1'b0;
    terr_d    = timeout_err;
    case (state)
      S_IDLE: if (start) begin
        terr_d    = 1'b0;
        written_d = '0;
        state_d   = (cfg_len == 11'd0) ? S_DONE : S_W_FETCH;
      end
      S_W_FETCH: begin
        inst_d[35] = 1'b1;
        inst_d[34] = 1'b1;
        if (cnt < ROW) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = w_base + cnt[10:0];
        end
        if (cnt != 12'd0) inst_d[2] = 1'b1;
        cnt_d = last ? 12'd0 : cnt + 12'd1;
        if (last) state_d = S_W_LOAD;
      end
      S_W_LOAD: begin
        inst_d[35] = 1'b1;
        inst_d[3]  = 1'b1;
        inst_d[0]  = 1'b1;
        cnt_d = last ? 12'd0 : cnt + 12'd1;
        if (last) state_d = S_W_SETTLE;
      end
      S_W_SETTLE: begin
        inst_d[35] = 1'b1;
        cnt_d = last ? 12'd0 : cnt + 12'd1;
        if (last) state_d = S_A_FETCH;
      end
      S_A_FETCH: begin
        inst_d[35] = 1'b1;
        if (cnt < {1'b0, len}) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = a_base + cnt[10:0];
        end
        if (cnt != 12'd0) inst_d[2] = 1'b1;
        cnt_d = last ? 12'd0 : cnt + 12'd1;
        if (last) state_d = S_EXEC;
      end
      S_EXEC: begin
        inst_d[35] = 1'b1;
        inst_d[3]  = 1'b1;
        inst_d[1]  = 1'b1;
        cnt_d = last ? 12'd0 : cnt + 12'd1;
        if (last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        inst_d[35] = 1'b1;
        if (ofifo_valid && (written < len)) begin
          inst_d[6]     = 1'b1;
          inst_d[50]    = 1'b0;
          inst_d[49]    = 1'b0;
          inst_d[48:38] = o_base + written;
          written_d     = written + 11'd1;
          if (written + 11'd1 == len) state_d = S_DONE;
        end else begin
          idle_d = idle + 1'b1;
          // Core stopped producing: abandon the remaining words.
          if (idle == TO_LAST) begin
            terr_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      written     <= '0;
      idle        <= '0;
      inst        <= IDLE_WORD;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      w_base      <= '0;
      a_base      <= '0;
      o_base      <= '0;
      len         <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      written     <= written_d;
      idle        <= idle_d;
      inst        <= inst_d;
      done        <= done_d;
      timeout_err <= terr_d;
      if (state == S_IDLE && start) begin
        w_base <= cfg_w_base;
        a_base <= cfg_a_base;
        o_base <= cfg_o_base;
        len    <= cfg_len;
      end
    end
  end
endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: per-cycle instruction words predicted from the
// phase rules, with randomized config, OFIFO valid and spurious starts.
module tb_inst_sequencer;
  localparam int ROW = 8, COL = 8, TO = 16;
  localparam logic [52:0] IDLE_W = 53'h0006_0001_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [10:0] cfg_w_base, cfg_a_base, cfg_o_base, cfg_len;
  logic [52:0] inst;
  logic        busy, done, timeout_err;

  int checks = 0, errors = 0;
  logic [52:0] exp_q[$];
  logic        vld[0:4095];

  always #5 clk = ~clk;

  inst_sequencer #(.row(ROW), .col(COL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_o_base(cfg_o_base),
    .cfg_len(cfg_len), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [52:0] f_addr(input logic [52:0] w, input int lsb, input int a);
    logic [10:0] v;
    v = 11'(a % 2048);
    for (int i = 0; i < 11; i++) w[lsb + i] = v[i];
    return w;
  endfunction

  // Expected word of every busy cycle (index i is the i+1-th cycle after start).
  task automatic build(input int w, input int a, input int o, input int len,
                       input int vmode, output int d, output bit to);
    logic [52:0] m, x;
    int ds, wr, idl, c, j;
    exp_q.delete();
    to = 1'b0;
    m = IDLE_W;
    m[35] = 1'b1;
    for (int i = 0; i < 4096; i++) vld[i] = 1'($urandom_range(0, 1));
    if (len > 0) begin
      for (int k = 0; k <= ROW; k++) begin
        x = m; x[34] = 1'b1;
        if (k < ROW) begin x[32] = 1'b0; x = f_addr(x, 20, w + k); end
        if (k > 0) x[2] = 1'b1;
        exp_q.push_back(x);
      end
      for (int k = 0; k < ROW; k++) begin x = m; x[3] = 1'b1; x[0] = 1'b1; exp_q.push_back(x); end
      for (int k = 0; k < COL; k++) exp_q.push_back(m);
      for (int k = 0; k <= len; k++) begin
        x = m;
        if (k < len) begin x[19] = 1'b0; x = f_addr(x, 7, a + k); end
        if (k > 0) x[2] = 1'b1;
        exp_q.push_back(x);
      end
      for (int k = 0; k < len; k++) begin x = m; x[3] = 1'b1; x[1] = 1'b1; exp_q.push_back(x); end
      ds = exp_q.size() + 1;
      for (int i = ds; i < 4096; i++) begin
        j = i - ds;
        case (vmode)
          0: vld[i] = 1'b1;
          1: vld[i] = 1'b0;
          3: vld[i] = (j % 4 == 0) || (j % 4 == 3);
          default: vld[i] = ($urandom_range(0, 3) != 0);
        endcase
      end
      wr = 0; idl = 0; c = ds;
      while (wr < len && !to) begin
        if (vld[c]) begin
          x = m; x[6] = 1'b1; x[50] = 1'b0; x[49] = 1'b0;
          exp_q.push_back(f_addr(x, 38, o + wr));
          wr++; idl = 0;
        end else begin
          exp_q.push_back(m);
          idl++;
          if (idl == TO) to = 1'b1;
        end
        c++;
      end
    end
    exp_q.push_back(IDLE_W);
    d = exp_q.size();
  endtask

  task automatic run_tile(input int w, input int a, input int o, input int len,
                          input int vmode, input bit junk, output int done_at);
    int d;
    bit to;
    logic [52:0] ew;
    build(w, a, o, len, vmode, d, to);
    @(negedge clk);
    cfg_w_base = 11'(w); cfg_a_base = 11'(a); cfg_o_base = 11'(o); cfg_len = 11'(len);
    start = 1'b1;
    ofifo_valid = vld[0];
    done_at = -1;
    for (int k = 1; k <= d + 2; k++) begin
      @(negedge clk);
      ew = (k >= 2 && k - 2 < d) ? exp_q[k - 2] : IDLE_W;
      chk($sformatf("inst c%0d", k), 64'(inst), 64'(ew));
      chk($sformatf("busy c%0d", k), 64'(busy), 64'(k <= d));
      chk($sformatf("done c%0d", k), 64'(done), 64'(k == d + 1));
      chk($sformatf("terr c%0d", k), 64'(timeout_err), 64'(to && k >= d));
      if (done && done_at < 0) done_at = k;
      start = (junk && k < d) ? 1'($urandom_range(0, 1)) : 1'b0;
      cfg_w_base = 11'($urandom); cfg_a_base = 11'($urandom);
      cfg_o_base = 11'($urandom); cfg_len = 11'($urandom);
      ofifo_valid = vld[k];
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  initial begin
    int dat;
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    cfg_w_base = '0; cfg_a_base = '0; cfg_o_base = '0; cfg_len = '0;
    repeat (2) @(negedge clk);
    chk("rst inst", 64'(inst), 64'(IDLE_W));
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst terr", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle inst", 64'(inst), 64'(IDLE_W));
    chk("idle busy", 64'(busy), 64'd0);

    run_tile(0, 100, 200, 16, 0, 1'b0, dat);
    chk("done latency", 64'(dat), 64'd76);
    run_tile(5, 2046, 7, 4, 2, 1'b1, dat);
    run_tile(10, 20, 2045, 3, 3, 1'b0, dat);
    run_tile(1, 2, 3, 5, 1, 1'b0, dat);
    chk("terr sticky", 64'(timeout_err), 64'd1);
    run_tile(2040, 30, 40, 2, 0, 1'b1, dat);
    run_tile(9, 9, 9, 0, 0, 1'b0, dat);

    // Reset in the middle of EXEC (len=8: EXEC spans cycles 35..42).
    begin
      @(negedge clk);
      cfg_w_base = 11'd3; cfg_a_base = 11'd4; cfg_o_base = 11'd5; cfg_len = 11'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (37) @(negedge clk);
      chk("pre-rst busy", 64'(busy), 64'd1);
      chk("pre-rst exec", 64'(inst[1]), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid-rst inst", 64'(inst), 64'(IDLE_W));
      chk("mid-rst busy", 64'(busy), 64'd0);
      chk("mid-rst done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk($sformatf("post-rst inst %0d", k), 64'(inst), 64'(IDLE_W));
        chk($sformatf("post-rst busy %0d", k), 64'(busy), 64'd0);
        chk($sformatf("post-rst done %0d", k), 64'(done), 64'd0);
      end
    end

    for (int t = 0; t < 10; t++)
      run_tile(int'($urandom_range(0, 2047)), int'($urandom_range(1990, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 24)),
               int'($urandom_range(0, 3)), 1'b1, dat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
